// File: rtl/tow_game_if.sv
// Press inputs and display outputs of the tug-of-war controller.
// master = press source / display side, slave = the controller.
interface tow_game_if #(
    parameter int NUM_LEDS = 9,
    parameter int SCORE_W  = 3
);
    logic                left_press;
    logic                right_press;
    logic [NUM_LEDS-1:0] leds;
    logic                left_round;
    logic                right_round;
    logic [SCORE_W-1:0]  left_score;
    logic [SCORE_W-1:0]  right_score;
    logic                match_over;
    logic                busy;

    modport master (
        output left_press, right_press,
        input  leds, left_round, right_round, left_score, right_score, match_over, busy
    );

    modport slave (
        input  left_press, right_press,
        output leds, left_round, right_round, left_score, right_score, match_over, busy
    );
endinterface

// File: rtl/tow_game_ctrl.sv
// Tug-of-war game controller: moves a one-hot rope light, scores rounds, ends the match.
// Optional per-player press lockout is enabled with `define TOW_LOCKOUT_EN.
module tow_game_ctrl #(
    parameter int NUM_LEDS  = 9,
    parameter int SCORE_W   = 3,
    parameter int MAX_SCORE = 3,
    parameter int WIN_HOLD  = 50000000,
    parameter int LOCKOUT   = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    tow_game_if.slave  bus
);
    localparam int CTR    = (NUM_LEDS - 1) / 2;
    localparam int POS_W  = $clog2(NUM_LEDS);
    localparam int HOLD_W = $clog2(WIN_HOLD + 1);
    localparam logic [NUM_LEDS-1:0] LEDS_WIN_L = ~((NUM_LEDS'(1) << CTR) - NUM_LEDS'(1));
    localparam logic [NUM_LEDS-1:0] LEDS_WIN_R = (NUM_LEDS'(1) << (CTR + 1)) - NUM_LEDS'(1);
    localparam logic [SCORE_W-1:0]  MAX_S      = SCORE_W'(MAX_SCORE);

    // A bad configuration references a module that does not exist, stopping elaboration.
    if (NUM_LEDS < 3 || (NUM_LEDS % 2) == 0 || MAX_SCORE < 1 ||
        MAX_SCORE > (2 ** SCORE_W) - 1 || WIN_HOLD < 1 || LOCKOUT < 1) begin : g_bad_cfg
        tow_game_ctrl_invalid_parameters u_invalid ();
    end

    typedef enum logic [2:0] {IDLE, PLAY, WIN_L, WIN_R, OVER} state_t;

    state_t              state_q, state_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [SCORE_W-1:0]  ls_q, ls_d, rs_q, rs_d;
    logic [NUM_LEDS-1:0] leds_q, leds_d;
    logic                lr_q, lr_d, rr_q, rr_d, mo_q, mo_d, busy_q, busy_d;
    logic                left_eff, right_eff, win_entry;

    function automatic logic [NUM_LEDS-1:0] onehot(input logic [POS_W-1:0] p);
        return NUM_LEDS'(1) << p;
    endfunction

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s >= MAX_S) ? MAX_S : s + 1'b1;
    endfunction

`ifdef TOW_LOCKOUT_EN
    localparam int LOCK_W = $clog2(LOCKOUT + 1);
    logic [LOCK_W-1:0] lk_l_q, lk_l_d, lk_r_q, lk_r_d;

    assign left_eff  = bus.left_press  && (lk_l_q == '0);
    assign right_eff = bus.right_press && (lk_r_q == '0);

    // A press counts as accepted (and arms its lockout) even when it cancels against the other.
    always_comb begin
        lk_l_d = (lk_l_q != '0) ? lk_l_q - 1'b1 : '0;
        lk_r_d = (lk_r_q != '0) ? lk_r_q - 1'b1 : '0;
        if (state_q == PLAY && left_eff)  lk_l_d = LOCK_W'(LOCKOUT - 1);
        if (state_q == PLAY && right_eff) lk_r_d = LOCK_W'(LOCKOUT - 1);
        if (win_entry) begin
            lk_l_d = '0;
            lk_r_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lk_l_q <= '0;
            lk_r_q <= '0;
        end else begin
            lk_l_q <= lk_l_d;
            lk_r_q <= lk_r_d;
        end
    end
`else
    assign left_eff  = bus.left_press;
    assign right_eff = bus.right_press;
`endif

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        hold_d    = hold_q;
        ls_d      = ls_q;
        rs_d      = rs_q;
        leds_d    = leds_q;
        lr_d      = lr_q;
        rr_d      = rr_q;
        win_entry = 1'b0;
        case (state_q)
            IDLE: begin
                leds_d = onehot(POS_W'(CTR));
                if (bus.left_press || bus.right_press) begin
                    state_d = PLAY;
                    pos_d   = POS_W'(CTR);
                end
            end
            PLAY: begin
                if (left_eff && !right_eff) begin
                    if (pos_q == POS_W'(NUM_LEDS - 1)) begin
                        state_d   = WIN_L;
                        ls_d      = sat_inc(ls_q);
                        lr_d      = 1'b1;
                        win_entry = 1'b1;
                    end else begin
                        pos_d = pos_q + 1'b1;
                    end
                end else if (right_eff && !left_eff) begin
                    if (pos_q == '0) begin
                        state_d   = WIN_R;
                        rs_d      = sat_inc(rs_q);
                        rr_d      = 1'b1;
                        win_entry = 1'b1;
                    end else begin
                        pos_d = pos_q - 1'b1;
                    end
                end
                if (win_entry) begin
                    hold_d = HOLD_W'(WIN_HOLD - 1);
                    leds_d = (state_d == WIN_L) ? LEDS_WIN_L : LEDS_WIN_R;
                end else begin
                    leds_d = onehot(pos_d);
                end
            end
            WIN_L, WIN_R: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - 1'b1;
                end else if (((state_q == WIN_L) ? ls_q : rs_q) == MAX_S) begin
                    state_d = OVER;
                end else begin
                    state_d = PLAY;
                    pos_d   = POS_W'(CTR);
                    leds_d  = onehot(POS_W'(CTR));
                    lr_d    = 1'b0;
                    rr_d    = 1'b0;
                end
            end
            OVER: ;
            default: state_d = IDLE;
        endcase
        mo_d   = (ls_d == MAX_S) || (rs_d == MAX_S);
        busy_d = (state_d == PLAY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pos_q   <= POS_W'(CTR);
            hold_q  <= '0;
            ls_q    <= '0;
            rs_q    <= '0;
            leds_q  <= onehot(POS_W'(CTR));
            lr_q    <= 1'b0;
            rr_q    <= 1'b0;
            mo_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            hold_q  <= hold_d;
            ls_q    <= ls_d;
            rs_q    <= rs_d;
            leds_q  <= leds_d;
            lr_q    <= lr_d;
            rr_q    <= rr_d;
            mo_q    <= mo_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.leds        = leds_q;
    assign bus.left_round  = lr_q;
    assign bus.right_round = rr_q;
    assign bus.left_score  = ls_q;
    assign bus.right_score = rs_q;
    assign bus.match_over  = mo_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_tow_game_ctrl.sv
// Scoreboard bench for tow_game_ctrl (NUM_LEDS=9, MAX_SCORE=2, WIN_HOLD=4, LOCKOUT=3).
module tb_tow_game_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;

    tow_game_if #(.NUM_LEDS(9), .SCORE_W(3)) bus ();

    tow_game_ctrl #(
        .NUM_LEDS(9), .SCORE_W(3), .MAX_SCORE(2), .WIN_HOLD(4), .LOCKOUT(3)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0] leds;
        logic       lr;
        logic       rr;
        logic [2:0] ls;
        logic [2:0] rs;
        logic       mo;
        logic       busy;
    } obs_t;

    typedef struct {
        logic rst;
        logic l;
        logic r;
        obs_t exp;
    } stim_t;

    localparam logic [8:0] CTR_LEDS = 9'b000010000;
    localparam logic [8:0] WL_LEDS  = 9'b111110000;
    localparam logic [8:0] WR_LEDS  = 9'b000011111;
`ifdef TOW_LOCKOUT_EN
    localparam int GAP = 2;
`else
    localparam int GAP = 1;
`endif

    obs_t  obs;
    stim_t stim_q[$];
    obs_t  sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    assign obs = {bus.leds, bus.left_round, bus.right_round, bus.left_score,
                  bus.right_score, bus.match_over, bus.busy};

    function automatic obs_t mk(logic [8:0] leds, logic lr, logic rr,
                                logic [2:0] ls, logic [2:0] rs, logic mo, logic busy);
        return {leds, lr, rr, ls, rs, mo, busy};
    endfunction

    function automatic obs_t play(int p, logic [2:0] ls, logic [2:0] rs);
        logic [8:0] one = 9'b1;
        return mk(one << p, 1'b0, 1'b0, ls, rs, 1'b0, 1'b1);
    endfunction

    function automatic obs_t idle_exp();
        return mk(CTR_LEDS, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    endfunction

    task automatic add(logic rst, logic l, logic r, obs_t exp);
        stim_t s;
        s.rst = rst; s.l = l; s.r = r; s.exp = exp;
        stim_q.push_back(s);
    endtask

    task automatic add_gap(obs_t exp);
        for (int k = 0; k < GAP; k++) add(1'b0, 1'b0, 1'b0, exp);
    endtask

    task automatic test_reset();
        stim_t s;
        obs_t  e;
        add(1, 0, 0, idle_exp());
        add(1, 0, 0, idle_exp());
        add(0, 0, 0, idle_exp());
        add(0, 0, 1, play(4, 0, 0));
        for (int i = 0; stim_q.size() > 0; i++) begin
            s = stim_q.pop_front();
            reset = s.rst; bus.left_press = s.l; bus.right_press = s.r;
            sb.push_back(s.exp);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL reset step %0d: got %b want %b (leds|lr|rr|ls|rs|mo|busy)", i, obs, e);
            end
        end
        reset = 0; bus.left_press = 0; bus.right_press = 0;
    endtask

    task automatic test_move();
        stim_t s;
        obs_t  e;
        add(0, 1, 0, play(5, 0, 0)); add_gap(play(5, 0, 0));
        add(0, 1, 0, play(6, 0, 0)); add_gap(play(6, 0, 0));
        add(0, 1, 1, play(6, 0, 0)); add_gap(play(6, 0, 0));
        add(0, 0, 1, play(5, 0, 0)); add_gap(play(5, 0, 0));
        add(0, 1, 0, play(6, 0, 0)); add_gap(play(6, 0, 0));
        for (int i = 0; stim_q.size() > 0; i++) begin
            s = stim_q.pop_front();
            reset = s.rst; bus.left_press = s.l; bus.right_press = s.r;
            sb.push_back(s.exp);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL move step %0d: got %b want %b (leds|lr|rr|ls|rs|mo|busy)", i, obs, e);
            end
        end
        bus.left_press = 0; bus.right_press = 0;
    endtask

    task automatic test_round_win();
        stim_t s;
        obs_t  e;
        obs_t  w1 = mk(WL_LEDS, 1'b1, 1'b0, 3'd1, 3'd0, 1'b0, 1'b0);
        add(0, 1, 0, play(7, 0, 0)); add_gap(play(7, 0, 0));
        add(0, 1, 0, play(8, 0, 0)); add_gap(play(8, 0, 0));
        add(0, 1, 0, w1);
        add(0, 0, 1, w1);
        add(0, 1, 0, w1);
        add(0, 0, 0, w1);
        add(0, 0, 0, play(4, 1, 0));
        for (int i = 0; stim_q.size() > 0; i++) begin
            s = stim_q.pop_front();
            reset = s.rst; bus.left_press = s.l; bus.right_press = s.r;
            sb.push_back(s.exp);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL round_win step %0d: got %b want %b (leds|lr|rr|ls|rs|mo|busy)", i, obs, e);
            end
        end
        bus.left_press = 0; bus.right_press = 0;
    endtask

    task automatic test_match_over();
        stim_t s;
        obs_t  e;
        obs_t  w2 = mk(WL_LEDS, 1'b1, 1'b0, 3'd2, 3'd0, 1'b1, 1'b0);
        for (int p = 5; p <= 8; p++) begin
            add(0, 1, 0, play(p, 1, 0));
            add_gap(play(p, 1, 0));
        end
        add(0, 1, 0, w2);
        for (int k = 0; k < 3; k++) add(0, 0, 0, w2);
        add(0, 1, 0, w2);
        add(0, 0, 1, w2);
        add(0, 1, 1, w2);
        for (int k = 0; k < 4; k++) add(0, 0, 0, w2);
        add(1, 0, 0, idle_exp());
        add(0, 0, 0, idle_exp());
        for (int i = 0; stim_q.size() > 0; i++) begin
            s = stim_q.pop_front();
            reset = s.rst; bus.left_press = s.l; bus.right_press = s.r;
            sb.push_back(s.exp);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL match_over step %0d: got %b want %b (leds|lr|rr|ls|rs|mo|busy)", i, obs, e);
            end
        end
        reset = 0; bus.left_press = 0; bus.right_press = 0;
    endtask

    task automatic test_mid_reset();
        stim_t s;
        obs_t  e;
        obs_t  wr = mk(WR_LEDS, 1'b0, 1'b1, 3'd0, 3'd1, 1'b0, 1'b0);
        add(0, 0, 1, play(4, 0, 0));
        for (int p = 3; p >= 0; p--) begin
            add(0, 0, 1, play(p, 0, 0));
            add_gap(play(p, 0, 0));
        end
        add(0, 0, 1, wr);
        for (int k = 0; k < 3; k++) add(0, 0, 0, wr);
        add(0, 0, 0, play(4, 0, 1));
        add(0, 0, 1, play(3, 0, 1)); add_gap(play(3, 0, 1));
        add(0, 0, 1, play(2, 0, 1));
        add(1, 0, 0, idle_exp());
        add(0, 0, 0, idle_exp());
        for (int i = 0; stim_q.size() > 0; i++) begin
            s = stim_q.pop_front();
            reset = s.rst; bus.left_press = s.l; bus.right_press = s.r;
            sb.push_back(s.exp);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL mid_reset step %0d: got %b want %b (leds|lr|rr|ls|rs|mo|busy)", i, obs, e);
            end
        end
        reset = 0; bus.left_press = 0; bus.right_press = 0;
    endtask

`ifdef TOW_LOCKOUT_EN
    task automatic test_lockout();
        stim_t s;
        obs_t  e;
        add(1, 0, 0, idle_exp());
        add(0, 1, 0, play(4, 0, 0));
        add(0, 1, 0, play(5, 0, 0));
        add(0, 1, 0, play(5, 0, 0));
        add(0, 1, 0, play(5, 0, 0));
        add(0, 1, 0, play(6, 0, 0));
        add(0, 1, 1, play(5, 0, 0));
        add(0, 0, 1, play(5, 0, 0));
        for (int i = 0; stim_q.size() > 0; i++) begin
            s = stim_q.pop_front();
            reset = s.rst; bus.left_press = s.l; bus.right_press = s.r;
            sb.push_back(s.exp);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL lockout step %0d: got %b want %b (leds|lr|rr|ls|rs|mo|busy)", i, obs, e);
            end
        end
        reset = 0; bus.left_press = 0; bus.right_press = 0;
    endtask
`else
    task automatic test_back_to_back();
        stim_t s;
        obs_t  e;
        add(1, 0, 0, idle_exp());
        add(0, 1, 0, play(4, 0, 0));
        add(0, 1, 0, play(5, 0, 0));
        add(0, 1, 0, play(6, 0, 0));
        add(0, 1, 0, play(7, 0, 0));
        add(0, 1, 1, play(7, 0, 0));
        add(0, 0, 1, play(6, 0, 0));
        for (int i = 0; stim_q.size() > 0; i++) begin
            s = stim_q.pop_front();
            reset = s.rst; bus.left_press = s.l; bus.right_press = s.r;
            sb.push_back(s.exp);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL back_to_back step %0d: got %b want %b (leds|lr|rr|ls|rs|mo|busy)", i, obs, e);
            end
        end
        reset = 0; bus.left_press = 0; bus.right_press = 0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.left_press  = 1'b0;
        bus.right_press = 1'b0;
        test_reset();
        test_move();
        test_round_win();
        test_match_over();
        test_mid_reset();
`ifdef TOW_LOCKOUT_EN
        test_lockout();
`else
        test_back_to_back();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
